// File: rtl/bios_watchdog_if.sv
// LPC-side signal bundle for the BIOS boot watchdog: register write strobe/value,
// POST byte, and the reset-request / flash-select / status outputs.
interface bios_watchdog_if;
    logic       WriteBiosWD;
    logic [7:0] BiosRegister;
    logic [7:0] BiosPostData;
    logic       RstReqN;
    logic       BiosSel;
    logic       WdActive;
    logic [7:0] WdStatus;

    modport master (
        output WriteBiosWD, BiosRegister, BiosPostData,
        input  RstReqN, BiosSel, WdActive, WdStatus
    );

    modport slave (
        input  WriteBiosWD, BiosRegister, BiosPostData,
        output RstReqN, BiosSel, WdActive, WdStatus
    );
endinterface

// File: rtl/bios_watchdog.sv
// BIOS boot watchdog: seconds-based timeout, platform reset pulse and dual-BIOS failover.
// Optional feature macro BIOS_WD_POST_KICK_EN: a change of the port-80 POST byte reloads the timer.
module bios_watchdog #(
    parameter int unsigned TICK_DIV  = 33_000_000,
    parameter int unsigned PULSE_LEN = 16
) (
    input  logic LpcClock,
    input  logic PciReset,
    bios_watchdog_if.slave bus
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned CW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_LEN - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    state_t        state_q,  state_d;
    logic [5:0]    count_q,  count_d;
    logic          fired_q,  fired_d;
    logic          sel_q,    sel_d;
    logic          rst_n_q,  rst_n_d;
    logic          active_q, active_d;
    logic [7:0]    status_q, status_d;
    logic [PW-1:0] presc_q,  presc_d;
    logic [CW-1:0] pulse_q,  pulse_d;
    logic          arm_s;
    logic          tick_s;
    logic          post_kick_s;
    logic [5:0]    reload_s;

`ifdef BIOS_WD_POST_KICK_EN
    logic [7:0]    post_q;
    logic [5:0]    timeout_q, timeout_d;

    assign post_kick_s = (bus.BiosPostData != post_q);
    assign reload_s    = timeout_q;
`else
    logic          unused_post_s;

    assign unused_post_s = ^bus.BiosPostData;
    assign post_kick_s   = 1'b0;
    assign reload_s      = 6'd0;
`endif

    assign arm_s  = bus.BiosRegister[7] && (bus.BiosRegister[5:0] != 6'd0);
    assign tick_s = (presc_q == PRESC_LAST);

    // Next-state logic: writes (outside EXPIRED) take precedence over POST kicks and ticks
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        fired_d = fired_q;
        sel_d   = sel_q;
        rst_n_d = rst_n_q;
        presc_d = presc_q;
        pulse_d = pulse_q;
`ifdef BIOS_WD_POST_KICK_EN
        timeout_d = timeout_q;
`endif
        if (bus.WriteBiosWD && (state_q != EXPIRED)) begin
            if (bus.BiosRegister[6]) begin
                fired_d = 1'b0;
            end else begin
                fired_d = fired_q;
            end
            presc_d = '0;
            if (arm_s) begin
                count_d = bus.BiosRegister[5:0];
                state_d = ARMED;
`ifdef BIOS_WD_POST_KICK_EN
                timeout_d = bus.BiosRegister[5:0];
`endif
            end else begin
                count_d = 6'd0;
                state_d = IDLE;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                ARMED: begin
                    if (post_kick_s) begin
                        count_d = reload_s;
                        presc_d = '0;
                    end else if (!tick_s) begin
                        presc_d = presc_q + 1'b1;
                    end else if (count_q > 6'd1) begin
                        presc_d = '0;
                        count_d = count_q - 6'd1;
                    end else if (count_q == 6'd1) begin
                        presc_d = '0;
                        count_d = 6'd0;
                        fired_d = 1'b1;
                        sel_d   = ~sel_q;
                        rst_n_d = 1'b0;
                        pulse_d = '0;
                        state_d = EXPIRED;
                    end else begin
                        // A zero count cannot be armed; fall back to idle rather than underflow
                        presc_d = '0;
                        state_d = IDLE;
                    end
                end
                EXPIRED: begin
                    if (pulse_q == PULSE_LAST) begin
                        rst_n_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        pulse_d = pulse_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = 6'd0;
                    rst_n_d = 1'b1;
                    presc_d = '0;
                    pulse_d = '0;
                end
            endcase
        end
        active_d = (state_d == ARMED);
        status_d = {active_d, fired_d, count_d};
    end

    // State and registered outputs; status is built from next-state values so it tracks them exactly
    always_ff @(posedge LpcClock) begin
        if (!PciReset) begin
            state_q  <= IDLE;
            count_q  <= 6'd0;
            fired_q  <= 1'b0;
            sel_q    <= 1'b0;
            rst_n_q  <= 1'b1;
            active_q <= 1'b0;
            status_q <= 8'h00;
            presc_q  <= '0;
            pulse_q  <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            fired_q  <= fired_d;
            sel_q    <= sel_d;
            rst_n_q  <= rst_n_d;
            active_q <= active_d;
            status_q <= status_d;
            presc_q  <= presc_d;
            pulse_q  <= pulse_d;
        end
    end

`ifdef BIOS_WD_POST_KICK_EN
    // Previous POST byte and last programmed timeout for POST-driven reloads
    always_ff @(posedge LpcClock) begin
        if (!PciReset) begin
            post_q    <= 8'h00;
            timeout_q <= 6'd0;
        end else begin
            post_q    <= bus.BiosPostData;
            timeout_q <= timeout_d;
        end
    end
`endif

    assign bus.RstReqN  = rst_n_q;
    assign bus.BiosSel  = sel_q;
    assign bus.WdActive = active_q;
    assign bus.WdStatus = status_q;

endmodule

// File: tb/tb_bios_watchdog.sv
// Scoreboard bench for bios_watchdog (TICK_DIV=4, PULSE_LEN=3): stimulus queues
// cycle-stamped expectations, a monitor compares every DUT output after each edge.
module tb_bios_watchdog;

    logic clk;
    logic PciReset;
    int   cyc_cnt;
    int   checks;
    int   failures;
    int   mon_i;
    int   e;

    typedef struct {
        int          cyc;
        string       name;
        logic [10:0] exp;
    } exp_t;

    exp_t sb_q[$];

    bios_watchdog_if bus();

    bios_watchdog #(.TICK_DIV(4), .PULSE_LEN(3)) dut (
        .LpcClock (clk),
        .PciReset (PciReset),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // expected vector: {RstReqN, BiosSel, WdActive, WdStatus}
    function automatic logic [10:0] ev(input logic rst, input logic sel, input logic act,
                                       input logic fired, input logic [5:0] cnt);
        return {rst, sel, act, act, fired, cnt};
    endfunction

    task automatic expect_at(input int c, input string n, input logic [10:0] v);
        sb_q.push_back('{c, n, v});
    endtask

    task automatic wait_cyc(input int c);
        while (cyc_cnt < c) @(negedge clk);
    endtask

    task automatic write_reg(input logic [7:0] v);
        bus.WriteBiosWD  = 1'b1;
        bus.BiosRegister = v;
        @(negedge clk);
        bus.WriteBiosWD  = 1'b0;
        bus.BiosRegister = 8'h00;
    endtask

    // Monitor: compare every expectation stamped for the edge just taken
    always @(posedge clk) begin
        #1;
        mon_i = 0;
        while (mon_i < sb_q.size()) begin
            if (sb_q[mon_i].cyc == cyc_cnt) begin
                checks++;
                if ({bus.RstReqN, bus.BiosSel, bus.WdActive, bus.WdStatus} !== sb_q[mon_i].exp) begin
                    failures++;
                    $display("FAIL %s cyc=%0d got={rst,sel,act,status}=%b_%b_%b_%h exp=%b_%b_%b_%h",
                             sb_q[mon_i].name, cyc_cnt, bus.RstReqN, bus.BiosSel, bus.WdActive,
                             bus.WdStatus, sb_q[mon_i].exp[10], sb_q[mon_i].exp[9],
                             sb_q[mon_i].exp[8], sb_q[mon_i].exp[7:0]);
                end
                sb_q.delete(mon_i);
            end else if (sb_q[mon_i].cyc < cyc_cnt) begin
                checks++;
                failures++;
                $display("FAIL %s missed check cyc=%0d now=%0d", sb_q[mon_i].name,
                         sb_q[mon_i].cyc, cyc_cnt);
                sb_q.delete(mon_i);
            end else begin
                mon_i++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "bench timeout");
    end

    initial begin
        cyc_cnt          = 0;
        checks           = 0;
        failures         = 0;
        PciReset         = 1'b0;
        bus.WriteBiosWD  = 1'b0;
        bus.BiosRegister = 8'h00;
        bus.BiosPostData = 8'h00;

        // 1. reset defaults
        @(negedge clk);
        @(negedge clk);
        e = cyc_cnt + 1;
        expect_at(e,     "reset_hold",  ev(1'b1, 1'b0, 1'b0, 1'b0, 6'd0));
        expect_at(e + 1, "reset_after", ev(1'b1, 1'b0, 1'b0, 1'b0, 6'd0));
        @(negedge clk);
        PciReset = 1'b1;
        wait_cyc(e + 2);

        // 2. expiry after 2 ticks
        e = cyc_cnt + 1;
        expect_at(e,      "arm_82",        ev(1'b1, 1'b0, 1'b1, 1'b0, 6'd2));
        expect_at(e + 4,  "first_tick",    ev(1'b1, 1'b0, 1'b1, 1'b0, 6'd1));
        expect_at(e + 7,  "pre_expiry",    ev(1'b1, 1'b0, 1'b1, 1'b0, 6'd1));
        expect_at(e + 8,  "expiry",        ev(1'b0, 1'b1, 1'b0, 1'b1, 6'd0));
        expect_at(e + 9,  "pulse_2",       ev(1'b0, 1'b1, 1'b0, 1'b1, 6'd0));
        expect_at(e + 10, "pulse_3",       ev(1'b0, 1'b1, 1'b0, 1'b1, 6'd0));
        expect_at(e + 11, "pulse_end",     ev(1'b1, 1'b1, 1'b0, 1'b1, 6'd0));
        write_reg(8'h82);
        wait_cyc(e + 12);

        // 3. kick at cycle 6 with timeout 3
        e = cyc_cnt + 1;
        expect_at(e,      "kick_arm",      ev(1'b1, 1'b1, 1'b1, 1'b1, 6'd2));
        expect_at(e + 4,  "kick_tick",     ev(1'b1, 1'b1, 1'b1, 1'b1, 6'd1));
        expect_at(e + 6,  "kick_reload",   ev(1'b1, 1'b1, 1'b1, 1'b1, 6'd3));
        expect_at(e + 8,  "kick_no_exp",   ev(1'b1, 1'b1, 1'b1, 1'b1, 6'd3));
        expect_at(e + 17, "kick_pre_exp",  ev(1'b1, 1'b1, 1'b1, 1'b1, 6'd1));
        expect_at(e + 18, "kick_expiry",   ev(1'b0, 1'b0, 1'b0, 1'b1, 6'd0));
        expect_at(e + 21, "kick_pulse_end", ev(1'b1, 1'b0, 1'b0, 1'b1, 6'd0));
        write_reg(8'h82);
        wait_cyc(e + 5);
        write_reg(8'h83);
        wait_cyc(e + 22);

        // 4. clear fired, then disarm while armed
        e = cyc_cnt + 1;
        expect_at(e,      "clear_fired",   ev(1'b1, 1'b0, 1'b0, 1'b0, 6'd0));
        expect_at(e + 1,  "rearm",         ev(1'b1, 1'b0, 1'b1, 1'b0, 6'd2));
        expect_at(e + 3,  "disarm",        ev(1'b1, 1'b0, 1'b0, 1'b0, 6'd0));
        expect_at(e + 12, "disarm_hold",   ev(1'b1, 1'b0, 1'b0, 1'b0, 6'd0));
        write_reg(8'h40);
        write_reg(8'h82);
        wait_cyc(e + 2);
        write_reg(8'h80);
        wait_cyc(e + 13);

        // 5a/5b. write on tick edge wins; write during EXPIRED ignored
        e = cyc_cnt + 1;
        expect_at(e,      "tick_arm",      ev(1'b1, 1'b0, 1'b1, 1'b0, 6'd2));
        expect_at(e + 4,  "tick_write",    ev(1'b1, 1'b0, 1'b1, 1'b0, 6'd2));
        expect_at(e + 11, "tick_pre_exp",  ev(1'b1, 1'b0, 1'b1, 1'b0, 6'd1));
        expect_at(e + 12, "tick_expiry",   ev(1'b0, 1'b1, 1'b0, 1'b1, 6'd0));
        expect_at(e + 13, "exp_write_ign", ev(1'b0, 1'b1, 1'b0, 1'b1, 6'd0));
        expect_at(e + 14, "exp_pulse_3",   ev(1'b0, 1'b1, 1'b0, 1'b1, 6'd0));
        expect_at(e + 15, "exp_pulse_end", ev(1'b1, 1'b1, 1'b0, 1'b1, 6'd0));
        expect_at(e + 16, "exp_idle",      ev(1'b1, 1'b1, 1'b0, 1'b1, 6'd0));
        write_reg(8'h82);
        wait_cyc(e + 3);
        write_reg(8'h82);
        wait_cyc(e + 12);
        write_reg(8'hC5);
        wait_cyc(e + 17);

        // 5c. reset during EXPIRED with BiosSel=1
        e = cyc_cnt + 1;
        expect_at(e,      "t1_arm",        ev(1'b1, 1'b1, 1'b1, 1'b1, 6'd1));
        expect_at(e + 4,  "t1_expiry",     ev(1'b0, 1'b0, 1'b0, 1'b1, 6'd0));
        expect_at(e + 7,  "t1_pulse_end",  ev(1'b1, 1'b0, 1'b0, 1'b1, 6'd0));
        expect_at(e + 8,  "t1_rearm",      ev(1'b1, 1'b0, 1'b1, 1'b1, 6'd1));
        expect_at(e + 12, "t1_expiry2",    ev(1'b0, 1'b1, 1'b0, 1'b1, 6'd0));
        expect_at(e + 13, "rst_in_exp",    ev(1'b1, 1'b0, 1'b0, 1'b0, 6'd0));
        expect_at(e + 14, "rst_released",  ev(1'b1, 1'b0, 1'b0, 1'b0, 6'd0));
        write_reg(8'h81);
        wait_cyc(e + 7);
        write_reg(8'h81);
        wait_cyc(e + 12);
        PciReset = 1'b0;
        @(negedge clk);
        PciReset = 1'b1;
        wait_cyc(e + 15);

        // 6. POST byte change at cycle 6
        e = cyc_cnt + 1;
        expect_at(e, "post_arm", ev(1'b1, 1'b0, 1'b1, 1'b0, 6'd2));
`ifdef BIOS_WD_POST_KICK_EN
        expect_at(e + 6,  "post_reload",   ev(1'b1, 1'b0, 1'b1, 1'b0, 6'd2));
        expect_at(e + 10, "post_tick",     ev(1'b1, 1'b0, 1'b1, 1'b0, 6'd1));
        expect_at(e + 13, "post_pre_exp",  ev(1'b1, 1'b0, 1'b1, 1'b0, 6'd1));
        expect_at(e + 14, "post_expiry",   ev(1'b0, 1'b1, 1'b0, 1'b1, 6'd0));
`else
        expect_at(e + 6,  "post_ignored",  ev(1'b1, 1'b0, 1'b1, 1'b0, 6'd1));
        expect_at(e + 8,  "post_expiry",   ev(1'b0, 1'b1, 1'b0, 1'b1, 6'd0));
        expect_at(e + 11, "post_pulse_end", ev(1'b1, 1'b1, 1'b0, 1'b1, 6'd0));
`endif
        write_reg(8'h82);
        wait_cyc(e + 5);
        bus.BiosPostData = 8'h55;
        wait_cyc(e + 16);

        @(negedge clk);
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain pending=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
